// File: rtl/mhd_pkg.sv
// Shared types and constants for the MHD error-statistics stage.
// Holds the FSM state enum, the drain length and the distance-width helper.
package mhd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DRAIN_CYCLES = 2;

    // Bits needed to hold a distance in 0..width.
    function automatic int hd_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mhd_accumulator_popcount.sv
// Combinational adder-tree popcount of the XOR difference word.
// Ports: data_i (WIDTH) difference word, count_o (HDW) number of set bits.
module hamming_popcount
    import mhd_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int HDW   = hd_width(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [HDW-1:0]   count_o
);

    localparam int P = 1 << $clog2(WIDTH);

    // Heap-ordered tree: leaves at P..2P-1, node i sums 2i and 2i+1.
    always_comb begin
        logic [P-1:0]   padded;
        logic [HDW-1:0] node [2*P];
        padded = '0;
        padded[WIDTH-1:0] = data_i;
        node[0] = '0;
        for (int i = 0; i < P; i++) begin
            node[P + i] = HDW'(padded[i]);
        end
        for (int i = P - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i + 1];
        end
        count_o = node[1];
    end

endmodule

// File: rtl/mhd_accumulator.sv
// Window error statistics over 2^LOG_SAMPLES exact/approx pairs.
// Ports: clk, rst_n; start; in_valid/in_ready + exact_word/approx_word in;
// res_valid/res_ready + hd_sum, err_cnt, max_hd, mhd_int out; busy.
// Optional macro MHD_ACC_MAX_TRACK_EN builds the max-distance tracker,
// otherwise max_hd is tied to 0.
module mhd_accumulator
    import mhd_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int LOG_SAMPLES = 10,
    localparam int HDW         = hd_width(WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           exact_word,
    input  logic [WIDTH-1:0]           approx_word,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [HDW+LOG_SAMPLES-1:0] hd_sum,
    output logic [LOG_SAMPLES:0]       err_cnt,
    output logic [HDW-1:0]             max_hd,
    output logic [HDW-1:0]             mhd_int,
    output logic                       busy
);

    localparam int N    = 1 << LOG_SAMPLES;
    localparam int CNTW = LOG_SAMPLES + 1;
    localparam int SUMW = HDW + LOG_SAMPLES;
    localparam int DCW  = $clog2(DRAIN_CYCLES + 1);

    state_e state_q, state_d;

    logic [CNTW-1:0]  smp_q, smp_d;
    logic [DCW-1:0]   drn_q, drn_d;

    logic [WIDTH-1:0] s1_diff_q;
    logic             s1_vld_q;
    logic [HDW-1:0]   s2_hd_q;
    logic             s2_vld_q;
    logic [HDW-1:0]   pc;

    logic [SUMW-1:0]  sum_q, sum_d;
    logic [CNTW-1:0]  err_q, err_d;

    logic open_win;
    logic accept;
    logic last_pair;
    logic drain_end;

    assign open_win  = (state_q == IDLE) && start;
    assign accept    = in_valid && in_ready;
    assign last_pair = accept && (smp_q == CNTW'(N - 1));
    assign drain_end = (drn_q == DCW'(DRAIN_CYCLES - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)     state_d = RUN;
            RUN:     if (last_pair) state_d = DRAIN;
            DRAIN:   if (drain_end) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == RUN) && (smp_q < CNTW'(N));
        res_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // ---------------- counters ----------------
    always_comb begin
        smp_d = smp_q;
        drn_d = drn_q;
        if (open_win) begin
            smp_d = '0;
            drn_d = '0;
        end else begin
            if (accept) begin
                smp_d = smp_q + 1'b1;
            end
            if (state_q == DRAIN) begin
                drn_d = drn_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q <= '0;
            drn_q <= '0;
        end else begin
            smp_q <= smp_d;
            drn_q <= drn_d;
        end
    end

    // ---------------- pipeline ----------------
    // Bubbles carry zero payload so a stale word never reaches S3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_diff_q <= '0;
            s1_vld_q  <= 1'b0;
            s2_hd_q   <= '0;
            s2_vld_q  <= 1'b0;
        end else begin
            s1_vld_q  <= accept;
            s1_diff_q <= accept ? (exact_word ^ approx_word) : '0;
            s2_vld_q  <= s1_vld_q;
            s2_hd_q   <= s1_vld_q ? pc : '0;
        end
    end

    hamming_popcount #(
        .WIDTH (WIDTH)
    ) u_pop (
        .data_i  (s1_diff_q),
        .count_o (pc)
    );

    // ---------------- accumulators ----------------
    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (open_win) begin
            sum_d = '0;
            err_d = '0;
        end else if (s2_vld_q) begin
            sum_d = sum_q + SUMW'(s2_hd_q);
            err_d = err_q + CNTW'(s2_hd_q != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            err_q <= '0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

`ifdef MHD_ACC_MAX_TRACK_EN
    logic [HDW-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (open_win) begin
            max_d = '0;
        end else if (s2_vld_q && (s2_hd_q > max_q)) begin
            max_d = s2_hd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_hd = max_q;
`else
    assign max_hd = '0;
`endif

    assign hd_sum  = sum_q;
    assign err_cnt = err_q;
    // Mean over N samples is a plain shift since N is a power of two.
    assign mhd_int = sum_q[SUMW-1:LOG_SAMPLES];

endmodule

// File: doc/mhd_accumulator.md
# mhd_accumulator

Error-statistics stage that consumes exact/approximate output word pairs from the miter. Per pair it computes the Hamming distance of the XOR difference and accumulates four figures over a fixed window of 2^LOG_SAMPLES vectors: distance sum, error count, maximum distance and mean Hamming distance (MHD). The window result is handed to the evaluation controller through a valid/ready result port.

## Interface
- WIDTH, 32, compared word width
- LOG_SAMPLES, 10, log2 of window length N
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that opens a window; honoured only in IDLE
- in_valid  in  1  pair valid
- in_ready  out  1  pair accepted when in_valid && in_ready
- exact_word  in  WIDTH  reference output word
- approx_word  in  WIDTH  approximate output word
- res_valid  out  1  window result available
- res_ready  in  1  result consumed when res_valid && res_ready
- hd_sum  out  HDW+LOG_SAMPLES  sum of distances, where HDW = $clog2(WIDTH+1)
- err_cnt  out  LOG_SAMPLES+1  number of pairs with distance ≠ 0
- max_hd  out  HDW  largest distance in the window
- mhd_int  out  HDW  hd_sum >> LOG_SAMPLES, truncated
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start. This clears the accumulators, the sample counter and the DRAIN counter.
- RUN: in_ready = 1 while sample counter < N. Each accepted pair increments the counter.
- RUN → DRAIN on the edge that accepts the N-th pair. in_ready drops that cycle.
- DRAIN lasts exactly 2 cycles while the pipeline empties, then moves to DONE.
- DONE: res_valid = 1. Result outputs are held stable until res_ready. On handshake, DONE → IDLE.
- start outside IDLE is ignored. It does not restart the window.
- in_valid outside RUN is ignored and no pair is accepted.
- Pipeline:
  - S1 registers exact_word ^ approx_word, qualified by a valid bit.
  - S2 registers popcount(diff), qualified by a valid bit.
  - S3 updates the accumulators when S2 is valid.
- Arithmetic per valid S2 distance d:
  - hd_sum += d. Cannot overflow, since N·WIDTH < 2^(HDW+LOG_SAMPLES).
  - err_cnt += (d ≠ 0). Reaches N at most.
  - max_hd = max(max_hd, d).
- mhd_int is combinational from hd_sum.
- Bubbles (in_valid low in RUN) stall nothing. The valid bits simply carry zeros through the pipeline.
- Reset mid-window: all state returns to IDLE, accumulators and pipeline valid bits clear, and the partial window is discarded.

## Timing
- Reset values: in_ready=0, res_valid=0, busy=0, hd_sum=0, err_cnt=0, max_hd=0, mhd_int=0.
- start sampled at edge T gives RUN and in_ready=1 from T+1.
- Pair accepted at edge E:
  - distance registered at E+1
  - accumulated at E+2
- Last pair accepted at edge E:
  - DRAIN from E
  - DONE and res_valid=1 from E+2; all accumulations are complete at E+2
- Minimum window time: N accepted cycles plus 3 cycles to res_valid.
- Result handshake at edge R gives IDLE, with res_valid=0 from R+1.
- A start in the same cycle as the result handshake is ignored, because the FSM is not yet in IDLE. Earliest effective start is at R+1.
- Accumulators keep their values in IDLE until the next start clears them.

## Configuration
- MHD_ACC_MAX_TRACK_EN defined: max_hd register and comparator are built as described.
- MHD_ACC_MAX_TRACK_EN undefined: no max logic is built and max_hd is tied to 0. All other behaviour and timing are unchanged.

## Structure
- Package mhd_pkg holds:
  - the state enum typedef (IDLE/RUN/DRAIN/DONE)
  - the function computing HDW from WIDTH
  - the DRAIN_CYCLES = 2 constant
- Sub-module hamming_popcount (parameter WIDTH): combinational adder-tree popcount of the XOR word, instantiated between S1 and S2.
- FSM, counters and accumulators live in the top level.

## Test plan
All directed tests use WIDTH=32, LOG_SAMPLES=2 (N=4).
- Pairs (0,0),(0,1),(0,0xFFFFFFFF),(0xF0,0x0F): hd_sum=41, err_cnt=3, max_hd=32, mhd_int=10.
- Four identical pairs: hd_sum=0, err_cnt=0, max_hd=0, mhd_int=0, with res_valid at E+2 after the last accept.
- in_valid toggling 1,0,0,1,1,0,1 with distances 1,2,3,4: hd_sum=10, err_cnt=4, in_ready low after the 4th accept, extra in_valid ignored.
- res_ready held low for 5 cycles in DONE: outputs stable, second start ignored; after handshake, busy=0 next cycle.
- rst_n asserted after 2 accepted pairs, then a new window of four 0xFFFFFFFF-vs-0 pairs: hd_sum=128, err_cnt=4, mhd_int=32, with no carryover from the aborted window.
- Build without MHD_ACC_MAX_TRACK_EN and rerun the first test: max_hd=0, all other outputs identical.
